// File: rtl/decode_writeback.sv
// ---------------------------------------------------------------------------
// decode_writeback
//   Decode and writeback stage of a Y86-64 style pipeline. It decodes register
//   IDs from the fetched instruction, reads operands from a 15-entry register
//   file, and commits execute and memory results on each rising clock edge.
//   A halt flag is set by the first non-ok fetch status and stays set until
//   reset. A retired-instruction counter counts committed instructions.
//
// Parameters
//   REG_INIT  reset value loaded into every architectural register
//   RSP_ID    register ID used as the stack pointer
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   opcode              {icode, ifun} from fetch
//   rArB                {rA, rB} register specifier byte from fetch
//   status              fetch status (0 ok, 1 halt, 2 bad addr, 3 bad instr)
//   cnd                 execute condition result, qualifies cmovXX
//   valE, valM          execute and memory results to write back
//   dbg_reg / dbg_val   debug read port (ID 15 reads 0)
//   srcA, srcB          decoded read IDs (4'hF = none)
//   dstE, dstM          decoded write IDs (4'hF = none)
//   valA, valB          operand values (pre-edge register contents)
//   halted              sticky stop flag
//   retired             committed instruction count
// ---------------------------------------------------------------------------

// One architectural register. The write enable already includes every
// qualification (decode hit, status, halt, reset), so the cell stays trivial.
module decode_writeback_reg #(
    parameter logic [63:0] INIT = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [63:0] d,
    output logic [63:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= INIT;
        else if (we)
            q <= d;
    end
endmodule

module decode_writeback #(
    parameter logic [63:0] REG_INIT = 64'h0,
    parameter logic [3:0]  RSP_ID   = 4'h4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  opcode,
    input  logic [7:0]  rArB,
    input  logic [1:0]  status,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic [3:0]  dbg_reg,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [63:0] dbg_val,
    output logic        halted,
    output logic [63:0] retired
);
    localparam logic [3:0] RNONE = 4'hF;

    // Instruction classes by icode
    localparam logic [3:0] I_RRMOVQ = 4'h2;  // also cmovXX
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    logic [3:0] icode;
    logic [3:0] ra;
    logic [3:0] rb;

    assign icode = opcode[7:4];
    assign ra    = rArB[7:4];
    assign rb    = rArB[3:0];

    // ------------------------------------------------------------------
    // Decode: purely combinational; unknown icodes fall to RNONE.
    // ------------------------------------------------------------------
    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (icode)
            I_RRMOVQ: begin
                srcA = ra;
                // cmovXX with a false condition writes nothing
                dstE = cnd ? rb : RNONE;
            end
            I_IRMOVQ: begin
                dstE = rb;
            end
            I_RMMOVQ: begin
                srcA = ra;
                srcB = rb;
            end
            I_MRMOVQ: begin
                srcB = rb;
                dstM = ra;
            end
            I_OPQ: begin
                srcA = ra;
                srcB = rb;
                dstE = rb;
            end
            I_CALL: begin
                srcB = RSP_ID;
                dstE = RSP_ID;
            end
            I_RET: begin
                srcA = RSP_ID;
                srcB = RSP_ID;
                dstE = RSP_ID;
            end
            I_PUSHQ: begin
                srcA = ra;
                srcB = RSP_ID;
                dstE = RSP_ID;
            end
            I_POPQ: begin
                srcA = RSP_ID;
                srcB = RSP_ID;
                dstE = RSP_ID;
                dstM = ra;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Writeback qualification
    // ------------------------------------------------------------------
    logic wb_en;

    assign wb_en = rst_n & (status == 2'd0) & ~halted;

    // ------------------------------------------------------------------
    // Register file. Entry 15 is a constant zero so every 4-bit ID indexes
    // a legal slot and "none" reads as 0 without extra muxing.
    // ------------------------------------------------------------------
    logic [15:0][63:0] rf;

    assign rf[15] = '0;

    for (genvar i = 0; i < 15; i++) begin : g_reg
        logic hit_e;
        logic hit_m;

        assign hit_e = wb_en && (dstE == 4'(i));
        assign hit_m = wb_en && (dstM == 4'(i));

        // valM takes priority when both ports target the same register,
        // which gives popq %rsp its load-wins behaviour.
        decode_writeback_reg #(
            .INIT (REG_INIT)
        ) u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (hit_e | hit_m),
            .d     (hit_m ? valM : valE),
            .q     (rf[i])
        );
    end

    // Reads see pre-edge contents; there is intentionally no bypass from
    // the write data.
    assign valA    = rf[srcA];
    assign valB    = rf[srcB];
    assign dbg_val = rf[dbg_reg];

    // ------------------------------------------------------------------
    // Halt flag and retire counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            halted <= 1'b0;
        else if (status != 2'd0)
            halted <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retired <= '0;
        else if (wb_en)
            retired <= retired + 64'd1;
    end

endmodule

// File: tb/tb_decode_writeback.sv
// ---------------------------------------------------------------------------
// tb_decode_writeback
//   Scoreboard bench. The stimulus process drives one instruction per cycle,
//   computes the expected combinational outputs and visible state from a
//   behavioural register-file model, and pushes them into a queue. A monitor
//   on the falling edge pops and compares. The model is updated after each
//   rising edge using the instruction semantics directly.
// ---------------------------------------------------------------------------
module tb_decode_writeback;
    localparam logic [63:0] INIT = 64'hA5A5_0000_1234_0001;
    localparam logic [3:0]  RSP  = 4'h4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  opcode;
    logic [7:0]  rArB;
    logic [1:0]  status;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dbg_reg;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [63:0] valA, valB, dbg_val;
    logic        halted;
    logic [63:0] retired;

    decode_writeback #(
        .REG_INIT (INIT),
        .RSP_ID   (RSP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .opcode  (opcode),
        .rArB    (rArB),
        .status  (status),
        .cnd     (cnd),
        .valE    (valE),
        .valM    (valM),
        .dbg_reg (dbg_reg),
        .srcA    (srcA),
        .srcB    (srcB),
        .dstE    (dstE),
        .dstM    (dstM),
        .valA    (valA),
        .valB    (valB),
        .dbg_val (dbg_val),
        .halted  (halted),
        .retired (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  srcA, srcB, dstE, dstM;
        logic [63:0] valA, valB, dbg_val;
        logic        halted;
        logic [63:0] retired;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [63:0] m_r[16];
    logic        m_halted;
    logic [63:0] m_retired;

    function automatic logic [3:0] f_srcA(logic [3:0] ic, logic [3:0] a);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return a;
        if (ic inside {4'h9, 4'hB}) return RSP;
        return 4'hF;
    endfunction

    function automatic logic [3:0] f_srcB(logic [3:0] ic, logic [3:0] b);
        if (ic inside {4'h4, 4'h5, 4'h6}) return b;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return RSP;
        return 4'hF;
    endfunction

    function automatic logic [3:0] f_dstE(logic [3:0] ic, logic [3:0] b, logic c);
        if (ic inside {4'h3, 4'h6}) return b;
        if (ic == 4'h2) return c ? b : 4'hF;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return RSP;
        return 4'hF;
    endfunction

    function automatic logic [3:0] f_dstM(logic [3:0] ic, logic [3:0] a);
        if (ic inside {4'h5, 4'hB}) return a;
        return 4'hF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_r[i] = INIT;
        m_r[15]   = '0;
        m_halted  = 1'b0;
        m_retired = '0;
    endtask

    // Effect of one rising edge with the current inputs (rst_n high).
    task automatic model_step();
        logic [3:0] de, dm;
        if (m_halted) return;
        if (status != 2'd0) begin
            m_halted = 1'b1;
            return;
        end
        de = f_dstE(opcode[7:4], rArB[3:0], cnd);
        dm = f_dstM(opcode[7:4], rArB[7:4]);
        if (de != 4'hF) m_r[de] = valE;
        if (dm != 4'hF) m_r[dm] = valM;   // load result wins on a clash
        m_retired = m_retired + 64'd1;
    endtask

    task automatic push_expected();
        exp_t e;
        e.srcA    = f_srcA(opcode[7:4], rArB[7:4]);
        e.srcB    = f_srcB(opcode[7:4], rArB[3:0]);
        e.dstE    = f_dstE(opcode[7:4], rArB[3:0], cnd);
        e.dstM    = f_dstM(opcode[7:4], rArB[7:4]);
        e.valA    = m_r[e.srcA];
        e.valB    = m_r[e.srcB];
        e.dbg_val = m_r[dbg_reg];
        e.halted  = m_halted;
        e.retired = m_retired;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1: set inputs, queue expectation, take one edge.
    task automatic drive(input logic [7:0] op, input logic [7:0] rr,
                         input logic [1:0] st, input logic c,
                         input logic [63:0] ve, input logic [63:0] vm,
                         input logic [3:0] dbg);
        opcode  = op;
        rArB    = rr;
        status  = st;
        cnd     = c;
        valE    = ve;
        valM    = vm;
        dbg_reg = dbg;
        push_expected();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Reset pulse between edges; the monitor samples while rst_n is low.
    task automatic reset_pulse(input logic [3:0] dbg);
        opcode  = 8'h10;
        rArB    = 8'hFF;
        status  = 2'd0;
        cnd     = 1'b0;
        dbg_reg = dbg;
        rst_n   = 1'b0;
        model_reset();
        push_expected();
        #6;
        rst_n = 1'b1;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("srcA", 64'(srcA), 64'(e.srcA));
                chk("srcB", 64'(srcB), 64'(e.srcB));
                chk("dstE", 64'(dstE), 64'(e.dstE));
                chk("dstM", 64'(dstM), 64'(e.dstM));
                chk("valA", valA, e.valA);
                chk("valB", valB, e.valB);
                chk("dbg_val", dbg_val, e.dbg_val);
                chk("halted", 64'(halted), 64'(e.halted));
                chk("retired", retired, e.retired);
            end
        end
    end

    // Stimulus
    initial begin
        rst_n   = 1'b0;
        opcode  = 8'h00;
        rArB    = 8'hFF;
        status  = 2'd0;
        cnd     = 1'b0;
        valE    = 64'd99;
        valM    = 64'd98;
        dbg_reg = 4'h2;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Reset state, with a pending write presented that must be ignored
        opcode = 8'h30;
        rArB   = 8'hF2;
        push_expected();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        opcode = 8'h10;
        @(posedge clk);
        model_step();
        #1;

        // irmovq $5, %rdx
        drive(8'h30, 8'hF2, 2'd0, 1'b0, 64'd5, 64'd0, 4'h2);
        // irmovq $3, %rcx
        drive(8'h30, 8'hF1, 2'd0, 1'b0, 64'd3, 64'd0, 4'h2);
        // OPq rA=1 rB=2, write 8 into R[2]; same-cycle read shows old 5
        drive(8'h60, 8'h12, 2'd0, 1'b0, 64'd8, 64'd0, 4'h2);
        // popq %rsp: valM wins
        drive(8'hB0, 8'h4F, 2'd0, 1'b0, 64'h108, 64'h77, 4'h4);
        // cmov not taken, then taken
        drive(8'h22, 8'h34, 2'd0, 1'b0, 64'd9, 64'd0, 4'h4);
        drive(8'h22, 8'h34, 2'd0, 1'b1, 64'd9, 64'd0, 4'h4);
        // pushq / call / ret / mrmovq / rmmovq
        drive(8'hA0, 8'h2F, 2'd0, 1'b0, 64'h200, 64'd0, 4'h4);
        drive(8'h80, 8'hFF, 2'd0, 1'b0, 64'h1F8, 64'd0, 4'h4);
        drive(8'h90, 8'hFF, 2'd0, 1'b0, 64'h200, 64'hDEAD, 4'h4);
        drive(8'h50, 8'h71, 2'd0, 1'b0, 64'h40, 64'hBEEF, 4'h7);
        drive(8'h40, 8'h71, 2'd0, 1'b0, 64'h40, 64'h0, 4'h7);
        // invalid icode decodes to none
        drive(8'hC3, 8'h12, 2'd0, 1'b1, 64'h1, 64'h2, 4'hF);
        // halt on bad instruction, then no further writes
        drive(8'h30, 8'hF2, 2'd3, 1'b0, 64'h55, 64'd0, 4'h2);
        drive(8'h30, 8'hF2, 2'd0, 1'b0, 64'h66, 64'd0, 4'h2);
        drive(8'h30, 8'hF2, 2'd0, 1'b0, 64'h67, 64'd0, 4'h2);
        drive(8'h10, 8'hFF, 2'd0, 1'b0, 64'h0, 64'd0, 4'h2);
        // asynchronous reset while halted
        reset_pulse(4'h2);
        drive(8'h10, 8'hFF, 2'd0, 1'b0, 64'h0, 64'd0, 4'h3);

        // Randomized phase
        for (int n = 0; n < 600; n++) begin
            logic [1:0] st;
            if (n % 75 == 74) begin
                reset_pulse(4'($urandom_range(0, 15)));
            end else begin
                st = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
                drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), st,
                      1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                      4'($urandom_range(0, 15)));
            end
        end

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
